// File: rtl/instrumented_adder_core_pkg.sv
// Shared constants for the instrumented ripple adder core.
// Register map, LA3 control bit positions and IO pad indices.
package instrumented_adder_core_pkg;

    localparam int DW   = 32;
    localparam int IO_W = 38;

    localparam logic [2:0] ADDR_A    = 3'd0;
    localparam logic [2:0] ADDR_B    = 3'd1;
    localparam logic [2:0] ADDR_EXT  = 3'd2;
    localparam logic [2:0] ADDR_RING = 3'd3;
    localparam logic [2:0] ADDR_TAP  = 3'd4;

    localparam int LA3_ADDR_LSB = 0;
    localparam int LA3_WR       = 3;
    localparam int LA3_RUN      = 4;

    localparam int IO_EXT   = 8;
    localparam int IO_FB    = 8;
    localparam int IO_CHAIN = 9;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] ext;
        logic [DW-1:0] ring;
        logic [DW-1:0] tap;
    } cfg_t;

endpackage

// File: rtl/instrumented_adder_core_if.sv
// Logic-analyzer banks, IO pads and project select of the adder core.
// master drives the inputs, slave is the user project.
interface instrumented_adder_core_if;
    import instrumented_adder_core_pkg::*;

    logic            active;
    logic [DW-1:0]   la1_data_in;
    logic [DW-1:0]   la1_data_out;
    logic [DW-1:0]   la1_oenb;
    logic [DW-1:0]   la2_data_in;
    logic [DW-1:0]   la2_data_out;
    logic [DW-1:0]   la2_oenb;
    logic [DW-1:0]   la3_data_in;
    logic [DW-1:0]   la3_data_out;
    logic [DW-1:0]   la3_oenb;
    logic [IO_W-1:0] io_in;
    logic [IO_W-1:0] io_out;
    logic [IO_W-1:0] io_oeb;

    modport master (
        output active, la1_data_in, la1_oenb,
        output la2_data_in, la2_oenb,
        output la3_data_in, la3_oenb, io_in,
        input  la1_data_out, la2_data_out,
        input  la3_data_out, io_out, io_oeb
    );

    modport slave (
        input  active, la1_data_in, la1_oenb,
        input  la2_data_in, la2_oenb,
        input  la3_data_in, la3_oenb, io_in,
        output la1_data_out, la2_data_out,
        output la3_data_out, io_out, io_oeb
    );

endinterface

// File: rtl/instrumented_adder.sv
// Operand mux, 32-bit adder, registered ring feedback node and
// the toggle / run-cycle measurement counters.
module instrumented_adder
    import instrumented_adder_core_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    input  logic [DW-1:0] ext_sel,
    input  logic [DW-1:0] ring_sel,
    input  logic [DW-1:0] tap_mask,
    input  logic          ext_bit,
    input  logic          run,
    output logic [DW-1:0] sum,
    output logic          chain_out,
    output logic          fb,
    output logic [DW-1:0] toggle_cnt,
    output logic [DW-1:0] cycle_cnt
);

    logic          fb_q, fb_d, fb_next;
    logic [DW-1:0] toggle_q, toggle_d;
    logic [DW-1:0] cycle_q, cycle_d;
    logic [DW-1:0] a_eff;

    // Per-bit operand select: ring feedback beats external pad beats register
    always_comb begin
        a_eff = (ring_sel & {DW{fb_q}})
              | (~ring_sel & ext_sel & {DW{ext_bit}})
              | (~ring_sel & ~ext_sel & a_in);
        {chain_out, sum} = {1'b0, a_eff} + {1'b0, b_in};
    end

    // Feedback and counters advance only while run is held
    always_comb begin
        fb_next  = ~^(sum & tap_mask);
        fb_d     = fb_q;
        toggle_d = toggle_q;
        cycle_d  = cycle_q;
        if (run) begin
            fb_d    = fb_next;
            cycle_d = cycle_q + 32'd1;
            if (fb_next != fb_q) begin
                toggle_d = toggle_q + 32'd1;
            end
        end
    end

    // Feedback node and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_q     <= 1'b0;
            toggle_q <= '0;
            cycle_q  <= '0;
        end else begin
            fb_q     <= fb_d;
            toggle_q <= toggle_d;
            cycle_q  <= cycle_d;
        end
    end

    assign fb         = fb_q;
    assign toggle_cnt = toggle_q;
    assign cycle_cnt  = cycle_q;

endmodule

// File: rtl/instrumented_adder_core.sv
// Instrumented adder user project: LA register decode, strobe edge
// detection and active gating of every output toward the pads.
module instrumented_adder_core
    import instrumented_adder_core_pkg::*;
(
    input  logic                      wb_clk_i,
    input  logic                      rst_n,
    instrumented_adder_core_if.slave  bus
);

    cfg_t          cfg_q, cfg_d;
    logic          strobe_q, strobe_d;
    logic          wr_edge;
    logic [2:0]    addr;
    logic [DW-1:0] sum, toggle_cnt, cycle_cnt;
    logic          chain_out, fb;
    logic          unused_ok;

    assign addr    = bus.la3_data_in[LA3_ADDR_LSB +: 3];
    assign wr_edge = bus.la3_data_in[LA3_WR] & ~strobe_q;

    // A rising strobe writes the LA1 word into the addressed register
    always_comb begin
        cfg_d    = cfg_q;
        strobe_d = bus.la3_data_in[LA3_WR];
        if (wr_edge) begin
            case (addr)
                ADDR_A:    cfg_d.a    = bus.la1_data_in;
                ADDR_B:    cfg_d.b    = bus.la1_data_in;
                ADDR_EXT:  cfg_d.ext  = bus.la1_data_in;
                ADDR_RING: cfg_d.ring = bus.la1_data_in;
                ADDR_TAP:  cfg_d.tap  = bus.la1_data_in;
                default:   ;
            endcase
        end
    end

    // Configuration registers and strobe history
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            cfg_q    <= cfg_d;
            strobe_q <= strobe_d;
        end
    end

    instrumented_adder u_adder (
        .clk        (wb_clk_i),
        .rst_n      (rst_n),
        .a_in       (cfg_q.a),
        .b_in       (cfg_q.b),
        .ext_sel    (cfg_q.ext),
        .ring_sel   (cfg_q.ring),
        .tap_mask   (cfg_q.tap),
        .ext_bit    (bus.io_in[IO_EXT]),
        .run        (bus.la3_data_in[LA3_RUN]),
        .sum        (sum),
        .chain_out  (chain_out),
        .fb         (fb),
        .toggle_cnt (toggle_cnt),
        .cycle_cnt  (cycle_cnt)
    );

    // Deselected project drives zeros and releases every pad
    always_comb begin
        bus.la1_data_out = '0;
        bus.la2_data_out = '0;
        bus.la3_data_out = '0;
        bus.io_out       = '0;
        bus.io_oeb       = '1;
        if (bus.active) begin
            bus.la1_data_out     = sum;
            bus.la2_data_out     = toggle_cnt;
            bus.la3_data_out     = cycle_cnt;
            bus.io_out[IO_FB]    = fb;
            bus.io_out[IO_CHAIN] = chain_out;
            bus.io_oeb[IO_FB]    = 1'b0;
            bus.io_oeb[IO_CHAIN] = 1'b0;
        end
    end

    assign unused_ok = ^{bus.la1_oenb, bus.la2_data_in, bus.la2_oenb,
                         bus.la3_oenb, bus.la3_data_in[DW-1:5],
                         bus.io_in[IO_W-1:9], bus.io_in[7:0]};

endmodule

// File: tb/tb_instrumented_adder_core.sv
// Self-checking bench for instrumented_adder_core.
// Directed scenarios then random traffic against a reference model.
module tb_instrumented_adder_core;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    logic [31:0] m_reg [5];
    logic        m_fb;
    logic [31:0] m_tog;
    logic [31:0] m_cyc;
    logic        m_prev;

    logic        run;
    logic        strobe;
    logic [2:0]  addr;

    instrumented_adder_core_if bus ();

    instrumented_adder_core dut (
        .wb_clk_i (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb bus.la3_data_in = {27'd0, run, strobe, addr};

    task automatic m_reset();
        for (int i = 0; i < 5; i++) m_reg[i] = '0;
        m_fb   = 1'b0;
        m_tog  = '0;
        m_cyc  = '0;
        m_prev = 1'b0;
    endtask

    function automatic logic [32:0] m_chain();
        logic [31:0] a;
        for (int i = 0; i < 32; i++) begin
            if (m_reg[3][i])      a[i] = m_fb;
            else if (m_reg[2][i]) a[i] = bus.io_in[8];
            else                  a[i] = m_reg[0][i];
        end
        return {1'b0, a} + {1'b0, m_reg[1]};
    endfunction

    task automatic step();
        logic [32:0] c;
        logic        nf;
        @(posedge clk);
        if (rst_n) begin
            c = m_chain();
            if (run) begin
                nf = ($countones(c[31:0] & m_reg[4]) % 2) == 0;
                if (nf != m_fb) m_tog = m_tog + 1;
                m_fb  = nf;
                m_cyc = m_cyc + 1;
            end
            if (strobe && !m_prev && addr < 3'd5)
                m_reg[addr] = bus.la1_data_in;
            m_prev = strobe;
        end
        #1;
    endtask

    task automatic chk(string tag, logic [37:0] obs, logic [37:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(string tag);
        logic [32:0] c;
        logic [37:0] io;
        c  = m_chain();
        io = '0;
        io[9] = c[32];
        io[8] = m_fb;
        if (bus.active) begin
            chk({tag, ".sum"}, 38'(bus.la1_data_out), 38'(c[31:0]));
            chk({tag, ".tog"}, 38'(bus.la2_data_out), 38'(m_tog));
            chk({tag, ".cyc"}, 38'(bus.la3_data_out), 38'(m_cyc));
            chk({tag, ".io"},  bus.io_out, io);
            chk({tag, ".oeb"}, bus.io_oeb, 38'h3F_FFFF_FCFF);
        end else begin
            chk({tag, ".sum0"}, 38'(bus.la1_data_out), '0);
            chk({tag, ".tog0"}, 38'(bus.la2_data_out), '0);
            chk({tag, ".cyc0"}, 38'(bus.la3_data_out), '0);
            chk({tag, ".io0"},  bus.io_out, '0);
            chk({tag, ".oeb1"}, bus.io_oeb, '1);
        end
    endtask

    task automatic write_reg(logic [2:0] a, logic [31:0] d);
        bus.la1_data_in = d;
        addr   = a;
        strobe = 1'b1;
        step();
        strobe = 1'b0;
        step();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_reset();
        rst_n  = 1'b0;
        run    = 1'b0;
        strobe = 1'b0;
        addr   = '0;
        bus.active      = 1'b1;
        bus.la1_data_in = '0;
        bus.la1_oenb    = '1;
        bus.la2_data_in = 32'hDEAD_BEEF;
        bus.la2_oenb    = '0;
        bus.la3_oenb    = '1;
        bus.io_in       = '0;

        // reset state
        repeat (3) step();
        check_all("rst");
        bus.active = 1'b0;
        #1 check_all("rst_inactive");
        bus.active = 1'b1;
        rst_n = 1'b1;
        step();
        check_all("post_rst");

        // carry out of all-ones plus one
        write_reg(3'd0, 32'hFFFF_FFFF);
        write_reg(3'd1, 32'd1);
        check_all("carry");
        chk("carry.sum", 38'(bus.la1_data_out), 38'd0);
        chk("carry.chain", 38'(bus.io_out[9]), 38'd1);

        // external pad operand
        write_reg(3'd2, 32'd1);
        write_reg(3'd0, 32'd0);
        write_reg(3'd1, 32'd0);
        bus.io_in[8] = 1'b0;
        #1 chk("ext0", 38'(bus.la1_data_out), 38'd0);
        bus.io_in[8] = 1'b1;
        #1 chk("ext1", 38'(bus.la1_data_out), 38'd1);
        check_all("ext");
        bus.io_in[8] = 1'b0;

        // ring oscillation with a following tap
        write_reg(3'd2, 32'd0);
        write_reg(3'd3, 32'd1);
        write_reg(3'd4, 32'd1);
        run = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            check_all("ring");
            chk("ring.fb", 38'(bus.io_out[8]), 38'(i % 2));
        end
        run = 1'b0;
        step();
        chk("ring.tog10", 38'(bus.la2_data_out), 38'd10);
        chk("ring.cyc10", 38'(bus.la3_data_out), 38'd10);

        // empty tap settles feedback at one
        write_reg(3'd4, 32'd0);
        run = 1'b1;
        repeat (5) begin
            step();
            check_all("tap0");
        end
        run = 1'b0;
        step();
        chk("tap0.fb", 38'(bus.io_out[8]), 38'd1);
        chk("tap0.tog", 38'(bus.la2_data_out), 38'd11);
        chk("tap0.cyc", 38'(bus.la3_data_out), 38'd15);

        // held strobe writes only the first address
        bus.la1_data_in = 32'd5;
        addr   = 3'd1;
        strobe = 1'b1;
        step();
        bus.la1_data_in = 32'd7;
        for (int i = 0; i < 4; i++) begin
            addr = 3'(i % 5);
            step();
            check_all("held");
        end
        strobe = 1'b0;
        step();
        write_reg(3'd3, 32'd0);
        chk("held.sum", 38'(bus.la1_data_out), 38'd5);
        check_all("held_end");

        // write and run in the same cycle use the pre-write sum
        write_reg(3'd4, 32'd1);
        bus.la1_data_in = 32'd6;
        addr   = 3'd1;
        strobe = 1'b1;
        run    = 1'b1;
        step();
        strobe = 1'b0;
        run    = 1'b0;
        check_all("wr_run");
        step();
        check_all("wr_run2");

        // asynchronous reset in the middle of a run
        run = 1'b1;
        repeat (3) step();
        #1 rst_n = 1'b0;
        m_reset();
        #1;
        chk("arst.tog", 38'(bus.la2_data_out), 38'd0);
        chk("arst.cyc", 38'(bus.la3_data_out), 38'd0);
        check_all("arst");
        run = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check_all("arst_rel");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bus.la1_data_in = $urandom;
            bus.la1_oenb    = $urandom;
            bus.io_in       = {$urandom, $urandom};
            bus.active      = ($urandom_range(0, 7) != 0);
            run    = $urandom_range(0, 1);
            strobe = $urandom_range(0, 1);
            addr   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) bus.la1_data_in = 32'h1 << $urandom_range(0, 31);
            step();
            check_all("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instrumented_adder_core.md
# instrumented_adder_core

Behavioural model of the instrumented 32-bit ripple adder user project, sitting inside the Caravel-style `active`-gated wrapper. It exposes configuration, operands and measurement counters through three 32-bit logic-analyzer (LA) banks and a few IO pads. The ring-oscillator path through the adder is modelled with a registered feedback node, so the model is fully synchronous and simulable and formally checkable.

## Interface
Parameters: none (widths fixed: data 32, IO 38).
- wb_clk_i  in  1  sole clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- active  in  1  project select; 0 = all outputs forced to idle values
- la1_data_in  in  32  data word for register writes
- la1_data_out  out  32  adder sum
- la1_oenb  in  32  LA direction bits, ignored
- la2_data_in  in  32  unused
- la2_data_out  out  32  ring toggle counter
- la2_oenb  in  32  ignored
- la3_data_in  in  32  control: [2:0] address, [3] write strobe, [4] run
- la3_data_out  out  32  run-cycle counter
- la3_oenb  in  32  ignored
- io_in  in  38  [8] external operand bit
- io_out  out  38  [8] feedback node, [9] chain_out, others 0
- io_oeb  out  38  0 on bits 8..9, 1 elsewhere

## Operation
- Registers, all 32 bits: a_input, b_input, a_input_ext_bit_b (per-bit external select), a_input_ring_bit_b (per-bit ring select), s_output_bit_b (sum tap mask).
- Write: rising edge of la3_data_in[3], sampled in wb_clk_i domain via one previous-value flop, writes la1_data_in to the addressed register. Addresses: 0 a_input, 1 b_input, 2 ext_bit_b, 3 ring_bit_b, 4 s_output_bit_b. Addresses 5–7 are no-ops. A held strobe writes once.
- Effective A, per bit i: if ring_bit_b[i] = 1, use fb. Else if ext_bit_b[i] = 1, use io_in[8]. Else use a_input[i]. Ring takes priority.
- sum[31:0], chain_out = {carry, sum} = a_eff + b_input, unsigned. Combinational.
- fb register: when run (la3_data_in[4]) = 1, each clock fb <= ~^(sum & s_output_bit_b). When run = 0, fb holds its value.
- toggle counter: +1 on each clock where run = 1 and the fb next value differs from the current value.
- cycle counter: +1 on each clock where run = 1.
- Counters wrap at 2^32. Writing any register does not clear the counters; only reset clears them.
- active = 0: la*_data_out = 0, io_out = 0, io_oeb = all 1s. Internal state keeps running.

## Timing
- Reset (async assert, release on clock edge): all registers, fb, counters and the strobe-edge flop go to 0. Outputs then read sum = 0, counters = 0, io_out = 0.
- Register write takes effect 1 cycle after the strobe edge is sampled. sum reflects it combinationally in the same cycle.
- fb and the counters update 1 cycle after run is sampled high.
- With a ring bit selected and a tap whose parity follows that bit, fb toggles every cycle (period 2 clocks).
- Write and run in the same cycle: fb uses the pre-write sum; the new value applies next cycle.
- Reset mid-run clears everything immediately; run must re-qualify after release.

## Structure
- Shared package: address constants (ADDR_A=0, ADDR_B=1, ADDR_EXT=2, ADDR_RING=3, ADDR_TAP=4), LA3 bit indices, IO bit indices (8, 9).
- One natural sub-module: `instrumented_adder`, holding the a_eff mux, the adder (output chain_out), fb and the counters.
- The top handles register decode and active gating.

## Test plan
- Reset → all outputs 0; io_oeb = 0x3F_FFFF_FCFF with active = 1, all 1s with active = 0.
- Write a = 0xFFFF_FFFF, b = 1 → la1_data_out = 0, io_out[9] (chain_out) = 1.
- Set ext_bit_b = 1, a = 0, b = 0, toggle io_in[8] → la1_data_out follows 0 / 1.
- ring_bit_b = 1, tap = 1, b = 0, run for 10 cycles → toggle counter = 10, cycle counter = 10, fb alternates.
- Tap = 0 with run → fb settles at 1 after 1 cycle, toggle counter = 1, then constant.
- Strobe held high for 5 cycles with the address changing → only the first address is written; asserting rst_n low mid-run → counters read 0 asynchronously.
